alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one combinational RV32I ALU instance between two requesters, e.g. the integer pipe and a branch/address unit.
- Arbitrates requests round-robin and holds the winner's operands for one execute cycle.
- Registers the ALU result and flags, then returns them to the winner over a valid/ready response channel.
- Sits between the requesters and the ALU. The ALU connects through the alu_* ports.

Parameters:
- N, 32, datapath width of operands and result.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op1  in  N  requester 0 operand 1
- req0_op2  in  N  requester 0 operand 2
- req0_op_code  in  3  requester 0 ALU op code
- req1_valid / req1_ready / req1_op1 / req1_op2 / req1_op_code  same as requester 0, for requester 1
- rsp0_valid  out  1  result pending for requester 0
- rsp0_ready  in  1  requester 0 takes result
- rsp1_valid  out  1  result pending for requester 1
- rsp1_ready  in  1  requester 1 takes result
- rsp_dout  out  N  registered ALU result, shared by both responders
- rsp_zero  out  1  registered zero flag
- rsp_sign  out  1  registered sign flag
- rsp_cry  out  1  registered carry flag
- alu_op1  out  N  to ALU operand 1
- alu_op2  out  N  to ALU operand 2
- alu_op_code  out  3  to ALU op code
- alu_dout  in  N  from ALU result
- alu_zero_flag  in  1  from ALU zero flag
- alu_sign_out  in  1  from ALU sign flag
- alu_cry_out  in  1  from ALU carry flag
- busy  out  1  state != IDLE

Behaviour:
- Single clock, clk. rst is synchronous, active-high, and sampled only on the rising edge.
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - Holding registers = 0, so alu_op1/alu_op2/alu_op_code = 0.
  - rsp*_valid = 0, rsp_dout/rsp_zero/rsp_sign/rsp_cry = 0, busy = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rules:
    - Only one reqX_valid is high: grant X, regardless of rr_ptr.
    - Both are high: grant requester rr_ptr.
  - reqX_ready is combinational: high only in IDLE, only for the granted X, and only while reqX_valid is high. The accept handshake is valid & ready.
  - On accept: latch op1/op2/op_code into holding registers, record grant id, go to EXEC.
  - No valid: stay in IDLE.
- EXEC:
  - alu_* ports are driven from the holding registers, never straight from the request ports.
  - At the clock edge, capture alu_dout and the three flags into the rsp_* registers, then go to RESP.
- RESP:
  - rsp<grant>_valid = 1; the other rsp valid = 0.
  - rsp_* values are held stable until the handshake.
  - On rsp<grant>_ready: rr_ptr <= ~grant, state goes to IDLE, rsp valid drops on the next cycle.
  - With ready held low, stay in RESP indefinitely (backpressure). The other requester waits; its req_ready stays 0.
- Latency and throughput:
  - Accept in cycle T gives rsp_valid in cycle T+2.
  - With rsp_ready already high, the next accept is at T+3. Peak throughput is 1 op per 3 cycles.
- Fairness: under continuous requests from both sides, grants strictly alternate 0,1,0,1...
- Request protocol: a requester keeps valid high and operands stable until accepted. The arbiter does not check this.
- Request/response overlap: a requester may re-assert valid while its own response is pending. It is not accepted until the FSM returns to IDLE.
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is issued, and rr_ptr returns to 0.
- Widths and op_code meaning:
  - No arithmetic inside the block; all N-bit and flag values pass through unmodified.
  - op_code is opaque and is forwarded to the ALU unchanged.

Optional Feature:
- Macro: ALU_RR_ARBITER_STATS_EN.
- Defined:
  - Adds outputs stat_grant0 and stat_grant1, 16 bits each.
  - Each increments on its requester's accept handshake and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench ALU model: dout = op1+op2 for op_code 3'b000, carry = bit N.
- Reset check: after rst, all outputs are 0, busy = 0, both req_ready = 0 with valids low.
- Single request: req0 op1=32'hFFFFFFFF, op2=32'hFFFF00F1, op_code=000, accepted at T.
  - Required: alu_op1 = FFFFFFFF in T+1; rsp0_valid at T+2 with rsp_dout = FFFF00F0, rsp_cry = 1, rsp_zero = 0, rsp_sign = 1.
  - Required: rsp1_valid = 0 throughout.
- Contention: both valid continuously for 4 ops, rsp ready tied high.
  - Required: grant order 0,1,0,1; accepts at cycles T, T+3, T+6, T+9.
- Backpressure: rsp0_ready low for 5 cycles while req1_valid is high.
  - Required: rsp0_valid and rsp_dout stay stable; req1_ready stays 0.
  - Required: req1 is accepted 1 cycle after rsp0_ready rises.
- Reset in RESP: assert rst for 1 cycle while rsp1_valid = 1.
  - Required: next cycle rsp1_valid = 0, state IDLE; with both valid, requester 0 is granted next.
- Stats (ALU_RR_ARBITER_STATS_EN): 3 accepts for req0 and 2 for req1 give stat_grant0 = 3, stat_grant1 = 2. Force the counter to FFFF and accept again: it stays FFFF.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; ALU_RR_ARBITER_STATS_EN adds grant counters.
// Latency: accept at T, registered result with rsp valid at T+2; one operation in flight, so at best 1 op per 3 cycles.
// Backpressure: a stalled response holds the FSM in RESP; no new request is accepted until the winner takes its result.
module alu_rr_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_op1,
  input  logic [N-1:0] req0_op2,
  input  logic [2:0]   req0_op_code,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_op1,
  input  logic [N-1:0] req1_op2,
  input  logic [2:0]   req1_op_code,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [N-1:0] rsp_dout,
  output logic         rsp_zero,
  output logic         rsp_sign,
  output logic         rsp_cry,
  output logic [N-1:0] alu_op1,
  output logic [N-1:0] alu_op2,
  output logic [2:0]   alu_op_code,
  input  logic [N-1:0] alu_dout,
  input  logic         alu_zero_flag,
  input  logic         alu_sign_out,
  input  logic         alu_cry_out,
  output logic         busy
`ifdef ALU_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]  stat_grant0,
  output logic [15:0]  stat_grant1
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic [2:0]   op_code;
  } alu_req_t;

  logic [1:0] state;
  logic       rr_ptr;
  logic       gnt_id;
  logic       gnt_sel;
  logic       accept;
  logic       rsp_hs;
  alu_req_t   hold_q;
  alu_req_t   req_mux;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    gnt_sel    = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = (state == IDLE) && req0_valid && !gnt_sel;
    req1_ready = (state == IDLE) && req1_valid && gnt_sel;
    accept     = req0_ready || req1_ready;
    req_mux    = gnt_sel ? {req1_op1, req1_op2, req1_op_code}
                         : {req0_op1, req0_op2, req0_op_code};
    rsp_hs     = (state == RESP) && (gnt_id ? rsp1_ready : rsp0_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      gnt_id   <= 1'b0;
      hold_q   <= '0;
      rsp_dout <= '0;
      rsp_zero <= 1'b0;
      rsp_sign <= 1'b0;
      rsp_cry  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold_q <= req_mux;
            gnt_id <= gnt_sel;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_dout <= alu_dout;
          rsp_zero <= alu_zero_flag;
          rsp_sign <= alu_sign_out;
          rsp_cry  <= alu_cry_out;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rr_ptr <= ~gnt_id;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ALU only ever sees the captured operands, so it is isolated from request-side churn.
  assign alu_op1     = hold_q.op1;
  assign alu_op2     = hold_q.op2;
  assign alu_op_code = hold_q.op_code;
  assign rsp0_valid  = (state == RESP) && !gnt_id;
  assign rsp1_valid  = (state == RESP) && gnt_id;
  assign busy        = (state != IDLE);

`ifdef ALU_RR_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0 <= 16'h0000;
      stat_grant1 <= 16'h0000;
    end else begin
      if (req0_valid && req0_ready && stat_grant0 != 16'hFFFF)
        stat_grant0 <= stat_grant0 + 16'd1;
      if (req1_valid && req1_ready && stat_grant1 != 16'hFFFF)
        stat_grant1 <= stat_grant1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus random traffic against a transaction-level reference model.
module tb_alu_rr_arbiter;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]   req0_op_code, req1_op_code;
  logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [N-1:0] rsp_dout;
  logic         rsp_zero, rsp_sign, rsp_cry;
  logic [N-1:0] alu_op1, alu_op2, alu_dout;
  logic [2:0]   alu_op_code;
  logic         alu_zero_flag, alu_sign_out, alu_cry_out;
  logic         busy;
`ifdef ALU_RR_ARBITER_STATS_EN
  logic [15:0]  stat_grant0, stat_grant1;
`endif

  alu_rr_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_op_code(req0_op_code),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_op_code(req1_op_code),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_dout(rsp_dout), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_cry(rsp_cry),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op_code(alu_op_code),
    .alu_dout(alu_dout), .alu_zero_flag(alu_zero_flag),
    .alu_sign_out(alu_sign_out), .alu_cry_out(alu_cry_out),
    .busy(busy)
`ifdef ALU_RR_ARBITER_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] alu_ref(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd1:    return {1'b0, a} + {1'b0, ~b} + 1;
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a << b[4:0]};
      3'd6:    return {1'b0, a >> b[4:0]};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // Bench ALU hooked to the alu_* ports.
  logic [N:0] alu_t;
  always_comb begin
    alu_t         = alu_ref(alu_op1, alu_op2, alu_op_code);
    alu_dout      = alu_t[N-1:0];
    alu_cry_out   = alu_t[N];
    alu_zero_flag = (alu_t[N-1:0] == '0);
    alu_sign_out  = alu_t[N-1];
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Requester-side intent and response readiness.
  logic         r_v   [2];
  logic [N-1:0] r_a   [2];
  logic [N-1:0] r_b   [2];
  logic [2:0]   r_op  [2];
  logic         rr    [2];

  // Reference model: one outstanding transaction, its phase, and the tie-break owner.
  int           m_stage = 0;
  int           m_g = 0;
  int           m_ptr = 0;
  logic [N-1:0] m_a, m_b, m_dout;
  logic [2:0]   m_op;
  logic         m_z, m_s, m_c;
  int           acc_id[$];
  int           acc_cyc[$];

  task automatic drive();
    req0_valid = r_v[0]; req0_op1 = r_a[0]; req0_op2 = r_b[0]; req0_op_code = r_op[0];
    req1_valid = r_v[1]; req1_op1 = r_a[1]; req1_op2 = r_b[1]; req1_op_code = r_op[1];
    rsp0_ready = rr[0];  rsp1_ready = rr[1];
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic run_cycle();
    int eg;
    logic [N:0] t;
    drive();
    #1;
    if (m_stage == 0) begin
      eg = (r_v[0] && r_v[1]) ? m_ptr : (r_v[1] ? 1 : 0);
      check("req0_ready", 64'(req0_ready), 64'(r_v[0] && eg == 0));
      check("req1_ready", 64'(req1_ready), 64'(r_v[1] && eg == 1));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_rsp_v", 64'({rsp1_valid, rsp0_valid}), 64'(0));
      if (r_v[0] || r_v[1]) begin
        m_g = eg; m_a = r_a[eg]; m_b = r_b[eg]; m_op = r_op[eg];
        t = alu_ref(m_a, m_b, m_op);
        m_dout = t[N-1:0]; m_c = t[N]; m_z = (t[N-1:0] == '0); m_s = t[N-1];
        acc_id.push_back(eg);
        acc_cyc.push_back(cyc);
        r_v[eg] = 1'b0;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      check("exec_rdy", 64'({req1_ready, req0_ready}), 64'(0));
      check("exec_busy", 64'(busy), 64'(1));
      check("exec_rsp_v", 64'({rsp1_valid, rsp0_valid}), 64'(0));
      check("alu_op1", 64'(alu_op1), 64'(m_a));
      check("alu_op2", 64'(alu_op2), 64'(m_b));
      check("alu_op_code", 64'(alu_op_code), 64'(m_op));
      m_stage = 2;
    end else begin
      check("rsp0_valid", 64'(rsp0_valid), 64'(m_g == 0));
      check("rsp1_valid", 64'(rsp1_valid), 64'(m_g == 1));
      check("rsp_dout", 64'(rsp_dout), 64'(m_dout));
      check("rsp_flags", 64'({rsp_zero, rsp_sign, rsp_cry}), 64'({m_z, m_s, m_c}));
      check("resp_rdy", 64'({req1_ready, req0_ready}), 64'(0));
      check("resp_busy", 64'(busy), 64'(1));
      if (rr[m_g]) begin
        m_stage = 0;
        m_ptr = 1 - m_g;
      end
    end
    nxt();
  endtask

  task automatic pulse_rst();
    drive();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    m_stage = 0;
    m_ptr = 0;
  endtask

  task automatic new_req(input int i);
    r_v[i] = 1'b1;
    r_a[i] = $urandom;
    r_b[i] = ($urandom_range(0, 5) == 0) ? -r_a[i] : $urandom;
    r_op[i] = 3'($urandom_range(0, 7));
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    r_v[i] = 1'b1; r_a[i] = a; r_b[i] = b; r_op[i] = 3'b000;
  endtask

  initial begin
    int base;
    int rise;
    for (int i = 0; i < 2; i++) begin
      r_v[i] = 1'b0; r_a[i] = '0; r_b[i] = '0; r_op[i] = '0; rr[i] = 1'b1;
    end
    rst = 1'b1;
    drive();
    nxt();
    pulse_rst();
    #1;
    check("rst_rsp_v", 64'({rsp1_valid, rsp0_valid}), 64'(0));
    check("rst_rsp_data", 64'({rsp_dout, rsp_zero, rsp_sign, rsp_cry}), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_req_rdy", 64'({req1_ready, req0_ready}), 64'(0));
    check("rst_alu", 64'({alu_op1, alu_op2, alu_op_code}), 64'(0));

    // Single request from requester 0.
    set_req(0, 32'hFFFFFFFF, 32'hFFFF00F1);
    run_cycle();
    check("single_alu_op1_T1", 64'(alu_op1), 64'h0000_0000_FFFF_FFFF);
    run_cycle();
    check("single_rsp0_valid_T2", 64'(rsp0_valid), 64'(1));
    check("single_dout_T2", 64'(rsp_dout), 64'h0000_0000_FFFF_00F0);
    check("single_cry_zero_sign", 64'({rsp_cry, rsp_zero, rsp_sign}), 64'(3'b101));
    run_cycle();

    // Contention: both requesters always have work, responses always taken.
    r_v[0] = 1'b0; r_v[1] = 1'b0;
    pulse_rst();
    base = acc_id.size();
    for (int k = 0; k < 20 && acc_id.size() < base + 4; k++) begin
      for (int i = 0; i < 2; i++) if (!r_v[i]) new_req(i);
      run_cycle();
    end
    check("contention_accepts", 64'(acc_id.size() >= base + 4), 64'(1));
    for (int j = 0; j < 4 && base + j < acc_id.size(); j++) begin
      check("contention_order", 64'(acc_id[base + j]), 64'(j % 2));
      check("contention_spacing", 64'(acc_cyc[base + j] - acc_cyc[base]), 64'(3 * j));
    end
    while (m_stage != 0) run_cycle();

    // Backpressure on requester 0 while requester 1 waits.
    r_v[0] = 1'b0; r_v[1] = 1'b0;
    pulse_rst();
    new_req(0);
    rr[0] = 1'b0; rr[1] = 1'b1;
    run_cycle();
    new_req(1);
    run_cycle();
    for (int k = 0; k < 5; k++) run_cycle();
    rr[0] = 1'b1;
    rise = cyc;
    run_cycle();
    run_cycle();
    check("bp_next_grant", 64'(acc_id[$]), 64'(1));
    check("bp_grant_cycle", 64'(acc_cyc[$]), 64'(rise + 1));

    // Reset while requester 1's response is pending.
    rr[1] = 1'b0;
    run_cycle();
    check("rresp_rsp1_valid", 64'(rsp1_valid), 64'(1));
    new_req(0);
    new_req(1);
    pulse_rst();
    #1;
    check("rresp_rsp1_dropped", 64'(rsp1_valid), 64'(0));
    check("rresp_idle", 64'(busy), 64'(0));
    rr[1] = 1'b1;
    run_cycle();
    check("rresp_grant0", 64'(acc_id[$]), 64'(0));
    while (m_stage != 0) run_cycle();

`ifdef ALU_RR_ARBITER_STATS_EN
    r_v[0] = 1'b0; r_v[1] = 1'b0;
    pulse_rst();
    for (int k = 0; k < 5; k++) begin
      new_req(k % 2);
      for (int c = 0; c < 3; c++) run_cycle();
    end
    check("stat_grant0", 64'(stat_grant0), 64'(3));
    check("stat_grant1", 64'(stat_grant1), 64'(2));
    force dut.stat_grant0 = 16'hFFFF;
    #1;
    release dut.stat_grant0;
    new_req(0);
    for (int c = 0; c < 3; c++) run_cycle();
    check("stat_grant0_sat", 64'(stat_grant0), 64'hFFFF);
`endif

    // Random traffic with occasional mid-operation resets.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!r_v[i] && $urandom_range(0, 2) != 0) new_req(i);
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 60) == 0) pulse_rst();
      else run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
